// File: rtl/inst_fetch_pkg.sv
// Shared fetch defines plus the package used by inst_fetch and fetch_queue.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned-redirect trap).
// The macros are global and are defined once, ahead of every other file.
`ifndef INST_FETCH_DEFINES
`define INST_FETCH_DEFINES
`define InstAddrBus 31:0
`define InstBus     31:0
`define ZeroWord    32'h00000000
`define ChipEnable  1'b1
`define ChipDisable 1'b0
`define FetchQDepth 2
`define PcResetAddr 32'h00000000
`endif

package inst_fetch_pkg;

  // One queue slot: the byte address of the instruction and the word itself.
  typedef struct packed {
    logic [`InstAddrBus] pc;
    logic [`InstBus]     inst;
  } fq_entry_t;

  localparam logic [1:0]          FQ_DEPTH = 2'(`FetchQDepth);
  localparam logic [`InstAddrBus] PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_queue.sv
// 2-entry, 64-bit synchronous FIFO with a flush input, push/pop and status.
// Push while full is ignored unless a pop happens in the same cycle.
// The head output holds its last value while the queue is empty.
module fetch_queue
  import inst_fetch_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       push_i,
  input  fq_entry_t  push_dat_i,
  input  logic       pop_i,
  output fq_entry_t  head_dat_o,
  output logic [1:0] count_o,
  output logic       full_o,
  output logic       empty_o
);

  fq_entry_t  mem_q [2];
  fq_entry_t  last_q;
  logic [1:0] count_q;
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic       pop_ok;
  logic       push_ok;

  assign full_o  = (count_q == FQ_DEPTH);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

  // A pop frees a slot in the same cycle, so a full queue can still accept a push.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // When empty, present whatever was last at the head instead of a stale slot.
  assign head_dat_o = empty_o ? last_q : mem_q[rd_ptr_q];

  // Pointer/count bookkeeping; flush empties the queue and overrides push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else if (flush_i) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= ~wr_ptr_q;
      if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
      if (push_ok && !pop_ok)      count_q <= count_q + 2'd1;
      else if (pop_ok && !push_ok) count_q <= count_q - 2'd1;
    end
  end

  // Storage plus a shadow of the head so the outputs hold once the queue drains.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      last_q   <= '0;
    end else begin
      if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
      if (!empty_o)            last_q <= mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: pc, ROM request, 2-entry buffer towards decode.
// Latency: word at pc is captured at the edge after rom_ce is high, visible next cycle.
// Backpressure: id_ready_i low lets the buffer fill, then pc holds. Macro: FETCH_ALIGN_CHECK_EN.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic                rom_ce_o,
  output logic [`InstAddrBus] rom_addr_o,
  input  logic [`InstBus]     rom_inst_i,
  output logic                id_valid_o,
  input  logic                id_ready_i,
  output logic [`InstAddrBus] id_pc_o,
  output logic [`InstBus]     id_inst_o,
  input  logic                branch_flag_i,
  input  logic [`InstAddrBus] branch_target_i
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                fetch_err_o
`endif
);

  logic [`InstAddrBus] pc_q;
  logic                rom_ce_q;
  logic                q_push;
  logic                q_pop;
  logic                q_full;
  logic                q_empty;
  logic [1:0]          q_count_unused;
  fq_entry_t           q_in;
  fq_entry_t           q_head;

`ifdef FETCH_ALIGN_CHECK_EN
  logic                err_q;
  assign fetch_err_o = err_q;
`else
  // Low target bits are dropped: every redirect lands on a word boundary.
  logic [1:0]          tgt_lo_unused;
  assign tgt_lo_unused = branch_target_i[1:0];
`endif

  assign rom_ce_o   = rom_ce_q;
  assign rom_addr_o = pc_q;
  assign id_valid_o = !q_empty;
  assign id_pc_o    = q_head.pc;
  assign id_inst_o  = q_head.inst;

  // A redirect discards the pop and suppresses the push in its cycle.
  assign q_pop  = id_valid_o && id_ready_i && !branch_flag_i;
  assign q_push = (rom_ce_q == `ChipEnable) && !branch_flag_i && (!q_full || q_pop);
  assign q_in   = '{pc: pc_q, inst: rom_inst_i};

  fetch_queue u_fetch_queue (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (branch_flag_i),
    .push_i     (q_push),
    .push_dat_i (q_in),
    .pop_i      (q_pop),
    .head_dat_o (q_head),
    .count_o    (q_count_unused),
    .full_o     (q_full),
    .empty_o    (q_empty)
  );

  // pc and ROM enable: redirect first, otherwise advance on every accepted fetch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= `PcResetAddr;
      rom_ce_q <= `ChipDisable;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else if (branch_flag_i) begin
`ifdef FETCH_ALIGN_CHECK_EN
      pc_q <= branch_target_i;
      if (branch_target_i[1:0] != 2'b00) begin
        rom_ce_q <= `ChipDisable;
        err_q    <= 1'b1;
      end else begin
        rom_ce_q <= `ChipEnable;
        err_q    <= 1'b0;
      end
`else
      pc_q     <= {branch_target_i[31:2], 2'b00};
      rom_ce_q <= `ChipEnable;
`endif
    end else begin
      if (q_push) pc_q <= pc_q + PC_STEP;
`ifdef FETCH_ALIGN_CHECK_EN
      if (!err_q) rom_ce_q <= `ChipEnable;
`else
      rom_ce_q <= `ChipEnable;
`endif
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: stream, stall, redirect, wrap, async reset.
// ROM word at byte address a is 0x1000_0000 + a/4.
// Inputs change and outputs are sampled at the falling edge.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        branch_flag;
  logic [31:0] branch_target;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_err;
`endif

  int vec_cnt  = 0;
  int miss_cnt = 0;

  assign rom_inst = 32'h1000_0000 + (rom_addr >> 2);

  inst_fetch dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .rom_ce_o        (rom_ce),
    .rom_addr_o      (rom_addr),
    .rom_inst_i      (rom_inst),
    .id_valid_o      (id_valid),
    .id_ready_i      (id_ready),
    .id_pc_o         (id_pc),
    .id_inst_o       (id_inst),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_err_o     (fetch_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset held over two edges, released at a falling edge with the given ready.
  task automatic apply_reset(input logic rdy);
    rst_n = 1'b0; id_ready = rdy; branch_flag = 1'b0; branch_target = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; id_ready = 1'b1; branch_flag = 1'b0; branch_target = 32'h0;
    repeat (2) @(negedge clk);
    vec_cnt++; if (rom_ce !== 1'b0) begin miss_cnt++; $display("FAIL reset_rom_ce got %b want 0", rom_ce); end
    vec_cnt++; if (rom_addr !== 32'h0) begin miss_cnt++; $display("FAIL reset_rom_addr got %h want 0", rom_addr); end
    vec_cnt++; if (id_valid !== 1'b0) begin miss_cnt++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
    vec_cnt++; if (id_pc !== 32'h0) begin miss_cnt++; $display("FAIL reset_id_pc got %h want 0", id_pc); end
    vec_cnt++; if (id_inst !== 32'h0) begin miss_cnt++; $display("FAIL reset_id_inst got %h want 0", id_inst); end
`ifdef FETCH_ALIGN_CHECK_EN
    vec_cnt++; if (fetch_err !== 1'b0) begin miss_cnt++; $display("FAIL reset_fetch_err got %b want 0", fetch_err); end
`endif
  endtask

  // id_ready high from release: first word two cycles after release, then gapless.
  task automatic test_stream;
    rst_n = 1'b1;
    @(negedge clk); // after E0
    vec_cnt++; if (rom_ce !== 1'b1) begin miss_cnt++; $display("FAIL stream_ce_e0 got %b want 1", rom_ce); end
    vec_cnt++; if (rom_addr !== 32'h0) begin miss_cnt++; $display("FAIL stream_addr_e0 got %h want 0", rom_addr); end
    vec_cnt++; if (id_valid !== 1'b0) begin miss_cnt++; $display("FAIL stream_valid_e0 got %b want 0", id_valid); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vec_cnt++; if (id_valid !== 1'b1) begin miss_cnt++; $display("FAIL stream_valid[%0d] got %b want 1", k, id_valid); end
      vec_cnt++; if (id_pc !== 32'(4 * k)) begin miss_cnt++; $display("FAIL stream_pc[%0d] got %h want %h", k, id_pc, 32'(4 * k)); end
      vec_cnt++; if (id_inst !== 32'h1000_0000 + 32'(k)) begin miss_cnt++; $display("FAIL stream_inst[%0d] got %h want %h", k, id_inst, 32'h1000_0000 + 32'(k)); end
      vec_cnt++; if (rom_addr !== 32'(4 * (k + 1))) begin miss_cnt++; $display("FAIL stream_addr[%0d] got %h want %h", k, rom_addr, 32'(4 * (k + 1))); end
    end
  endtask

  // id_ready low: two pushes fill the queue, pc holds at 0x8, order preserved on release.
  task automatic test_stall;
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
    apply_reset(1'b0);
    repeat (3) @(negedge clk); // E0, E1, E2
    for (int c = 0; c < 3; c++) begin
      vec_cnt++; if (rom_addr !== 32'h8) begin miss_cnt++; $display("FAIL stall_addr_hold[%0d] got %h want 00000008", c, rom_addr); end
      vec_cnt++; if (id_pc !== 32'h0) begin miss_cnt++; $display("FAIL stall_head[%0d] got %h want 0", c, id_pc); end
      @(negedge clk);
    end
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vec_cnt++; if (id_valid !== 1'b1 || id_pc !== exp_pc[k]) begin miss_cnt++; $display("FAIL stall_drain[%0d] got v=%b pc=%h want v=1 pc=%h", k, id_valid, id_pc, exp_pc[k]); end
      @(negedge clk);
    end
  endtask

  // Redirect to 0x40 with a full queue: bubble, then target at head; stale words never shown.
  task automatic test_redirect;
    apply_reset(1'b0);
    repeat (3) @(negedge clk); // queue holds 0x0 and 0x4
    id_ready = 1'b1; branch_flag = 1'b1; branch_target = 32'h40;
    @(negedge clk);
    branch_flag = 1'b0;
    vec_cnt++; if (id_valid !== 1'b0) begin miss_cnt++; $display("FAIL redir_bubble got %b want 0", id_valid); end
    vec_cnt++; if (rom_addr !== 32'h40) begin miss_cnt++; $display("FAIL redir_addr got %h want 00000040", rom_addr); end
    @(negedge clk);
    vec_cnt++; if (id_valid !== 1'b1 || id_pc !== 32'h40) begin miss_cnt++; $display("FAIL redir_target got v=%b pc=%h want v=1 pc=00000040", id_valid, id_pc); end
    vec_cnt++; if (id_inst !== 32'h1000_0010) begin miss_cnt++; $display("FAIL redir_inst got %h want 10000010", id_inst); end
    @(negedge clk);
    vec_cnt++; if (id_pc !== 32'h44) begin miss_cnt++; $display("FAIL redir_next got %h want 00000044", id_pc); end
  endtask

  // Redirect to the last word: pc wraps to 0 after it is fetched.
  task automatic test_wrap;
    branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    branch_flag = 1'b0;
    @(negedge clk);
    vec_cnt++; if (rom_addr !== 32'h0) begin miss_cnt++; $display("FAIL wrap_addr got %h want 0", rom_addr); end
    vec_cnt++; if (id_pc !== 32'hFFFF_FFFC) begin miss_cnt++; $display("FAIL wrap_pc0 got %h want fffffffc", id_pc); end
    vec_cnt++; if (id_inst !== 32'h4FFF_FFFF) begin miss_cnt++; $display("FAIL wrap_inst0 got %h want 4fffffff", id_inst); end
    @(negedge clk);
    vec_cnt++; if (id_pc !== 32'h0 || id_inst !== 32'h1000_0000) begin miss_cnt++; $display("FAIL wrap_pc1 got pc=%h inst=%h want pc=0 inst=10000000", id_pc, id_inst); end
  endtask

  // Reset asserted between edges with one entry queued clears outputs at once.
  task automatic test_async_reset;
    vec_cnt++; if (id_valid !== 1'b1) begin miss_cnt++; $display("FAIL areset_pre_valid got %b want 1", id_valid); end
    #1 rst_n = 1'b0;
    #1;
    vec_cnt++; if (rom_ce !== 1'b0 || rom_addr !== 32'h0) begin miss_cnt++; $display("FAIL areset_rom got ce=%b addr=%h want ce=0 addr=0", rom_ce, rom_addr); end
    vec_cnt++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0) begin miss_cnt++; $display("FAIL areset_id got v=%b pc=%h inst=%h want all 0", id_valid, id_pc, id_inst); end
    @(negedge clk);
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  // Misaligned redirect traps fetch until an aligned redirect resumes it.
  task automatic test_align;
    apply_reset(1'b1);
    repeat (4) @(negedge clk);
    branch_flag = 1'b1; branch_target = 32'h42;
    @(negedge clk);
    branch_flag = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vec_cnt++; if (fetch_err !== 1'b1 || rom_ce !== 1'b0) begin miss_cnt++; $display("FAIL align_err[%0d] got err=%b ce=%b want err=1 ce=0", c, fetch_err, rom_ce); end
      vec_cnt++; if (id_valid !== 1'b0 || rom_addr !== 32'h42) begin miss_cnt++; $display("FAIL align_nofetch[%0d] got v=%b addr=%h want v=0 addr=00000042", c, id_valid, rom_addr); end
      @(negedge clk);
    end
    branch_flag = 1'b1; branch_target = 32'h80;
    @(negedge clk);
    branch_flag = 1'b0;
    vec_cnt++; if (fetch_err !== 1'b0 || rom_ce !== 1'b1) begin miss_cnt++; $display("FAIL align_clear got err=%b ce=%b want err=0 ce=1", fetch_err, rom_ce); end
    @(negedge clk);
    vec_cnt++; if (id_valid !== 1'b1 || id_pc !== 32'h80) begin miss_cnt++; $display("FAIL align_resume got v=%b pc=%h want v=1 pc=00000080", id_valid, id_pc); end
  endtask
`else
  // Without the trap, low target bits are cleared when loaded into pc.
  task automatic test_unaligned_mask;
    branch_flag = 1'b1; branch_target = 32'h42;
    @(negedge clk);
    branch_flag = 1'b0;
    vec_cnt++; if (rom_addr !== 32'h40 || rom_ce !== 1'b1) begin miss_cnt++; $display("FAIL mask_addr got addr=%h ce=%b want addr=00000040 ce=1", rom_addr, rom_ce); end
    @(negedge clk);
    vec_cnt++; if (id_valid !== 1'b1 || id_pc !== 32'h40) begin miss_cnt++; $display("FAIL mask_head got v=%b pc=%h want v=1 pc=00000040", id_valid, id_pc); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; id_ready = 1'b1; branch_flag = 1'b0; branch_target = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_async_reset();
`ifdef FETCH_ALIGN_CHECK_EN
    test_align();
`else
    apply_reset(1'b1);
    repeat (3) @(negedge clk);
    test_unaligned_mask();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch front end, the requester side of the instruction ROM port. It drives the ROM chip-enable and byte address from its program counter and captures the combinationally returned instruction word. Fetched words are buffered in a 2-entry queue and handed to the decode stage with a valid/ready handshake. It sits between the instruction ROM and the IF/ID boundary and accepts branch redirects from the execute stage.

## Interface
- No parameters. Widths come from the shared defines: `InstAddrBus` = 32 bits, `InstBus` = 32 bits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rom_ce  output  1  ROM chip enable (`ChipEnable`/`ChipDisable`).
- rom_addr  output  32  ROM byte address; equals the internal pc.
- rom_inst  input  32  ROM data; valid in the same cycle as rom_addr while rom_ce is enabled.
- id_valid  output  1  buffer head holds an instruction.
- id_ready  input  1  decode accepts the head this cycle.
- id_pc  output  32  address of the head instruction.
- id_inst  output  32  head instruction word.
- branch_flag  input  1  redirect request, sampled at the clock edge.
- branch_target  input  32  redirect byte address.
- fetch_err  output  1  misaligned redirect; present only with FETCH_ALIGN_CHECK_EN.

## Operation
- Reset values: pc=0x00000000, rom_ce=`ChipDisable`, buffer count=0, id_valid=0, id_pc=0, id_inst=`ZeroWord`, fetch_err=0.
- rom_ce is registered. It rises to `ChipEnable` on the first edge after reset release and stays enabled thereafter, except in the error state.
- rom_addr = pc, combinational from the register. rom_addr is valid only while rom_ce is enabled.
- Pop: id_valid && id_ready at an edge removes the head entry.
- Push: rom_ce enabled and the queue has space at an edge writes {pc, rom_inst} at the tail, and pc <= pc + 4.
  - Space means count < 2, or count == 2 with a pop in the same cycle.
- Simultaneous push and pop keeps count unchanged and preserves order.
- When no push occurs, pc holds and rom_addr holds.
- pc wraps modulo 2^32: 0xFFFFFFFC + 4 = 0x00000000.
- Redirect (branch_flag=1 at an edge) has priority over push and pop. Its effects at that edge:
  - the queue is emptied, count=0;
  - pc <= branch_target;
  - no push occurs and any pop is discarded;
  - id_valid is 0 in the next cycle.
- id_pc and id_inst are the head entry contents. When count == 0 they hold their last values.
- Asserting rst mid-operation immediately clears all state to the reset values.

## Timing
- Reset release edge E0: rom_ce becomes enabled, rom_addr=0.
- Edge E1: the word at address 0 is pushed.
- Cycle after E1: id_valid=1, id_pc=0.
- Steady state: one instruction per cycle while id_ready=1.
- Redirect latency: flag at edge R, target fetched at edge R+1, id_valid=1 with id_pc=target after R+1.
- The internal queue state is 2 bits of count plus 1 bit each of read and write pointer, with pointers wrapping at 2.
- With id_ready=0, the queue fills in two pushes, after which pc and rom_addr hold.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect whose branch_target[1:0] != 0 sets fetch_err=1, empties the queue and forces rom_ce to `ChipDisable`.
  - No fetch occurs until the next aligned redirect, which clears fetch_err and resumes fetch.
  - pc still loads the misaligned value while in the error state.
- `FETCH_ALIGN_CHECK_EN` undefined:
  - The fetch_err port does not exist.
  - branch_target[1:0] is forced to 0 when loaded into pc.

## Structure
- Use the existing shared defines file for `InstAddrBus`, `InstBus`, `ZeroWord`, `ChipEnable` and `ChipDisable`.
- Add to the same defines file: `FetchQDepth` = 2 and `PcResetAddr` = 32'h0.
- One sub-module, `fetch_queue`: a 2-entry, 64-bit synchronous FIFO with a flush input, a push/pop interface and count, full and empty outputs.
- `inst_fetch` owns pc, rom_ce, redirect priority and the error state.

## Test plan
- Reset release with id_ready=1 held high, ROM word k = 0x1000_0000+k:
  - rom_addr steps 0, 4, 8, …;
  - id_valid rises 2 cycles after release;
  - id_inst sequence is 0x10000000, 0x10000001, … with no gaps.
- id_ready=0 for 5 cycles:
  - count reaches 2 and rom_addr holds at 0x8 while 0x0 and 0x4 are queued;
  - on raising id_ready, the output order is 0x0, 0x4, 0x8 with no loss or duplication.
- Redirect to 0x40 while the queue is full and id_ready=1:
  - the next cycle has id_valid=0;
  - the following cycle has id_pc=0x40;
  - the stale entries 0x0 and 0x4 are never presented.
- pc=0xFFFFFFFC pushed: the next rom_addr=0x00000000 and id_pc follows 0xFFFFFFFC, 0x0.
- rst asserted mid-stream with count=1: outputs return to the reset values asynchronously, before the next clock edge.
- With `FETCH_ALIGN_CHECK_EN` defined:
  - redirect to 0x42 gives fetch_err=1, rom_ce disabled and no pushes for 4 cycles;
  - a following redirect to 0x80 clears fetch_err and id_pc=0x80 appears 2 edges later.
